exo1_mul_arbiter: RTL and testbench

EXO1_MUL_ARBITER -- requirements
Module: exo1_mul_arbiter

---
 rtl/exo1_mul_pkg.sv | 18 +
 rtl/exo1_mul_32s_32s_32_2_1.sv | 36 +++
 rtl/exo1_mul_arbiter.sv | 116 +++++++++++
 tb/tb_exo1_mul_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/exo1_mul_pkg.sv
`default_nettype none
// ============================================================================
// Module   : exo1_mul_pkg
// Purpose  : Shared defaults and id-width helper for the multiplier arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package exo1_mul_pkg;

  localparam int C_NREQ_DEFAULT = 4;
  localparam int C_W_DEFAULT    = 32;

  // At least one id bit, even for a degenerate single-requester build.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/exo1_mul_32s_32s_32_2_1.sv
`default_nettype none
// ============================================================================
// Module   : exo1_mul_32s_32s_32_2_1
// Purpose  : Signed multiplier, product truncated to dout_WIDTH, output register.
// Revision : 1.0 - initial release
// ============================================================================
module exo1_mul_32s_32s_32_2_1 #(
  parameter int din0_WIDTH = 32,
  parameter int din1_WIDTH = 32,
  parameter int dout_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  i_ce,
  input  logic [din0_WIDTH-1:0] i_din0,
  input  logic [din1_WIDTH-1:0] i_din1,
  output logic [dout_WIDTH-1:0] o_dout
);

  logic signed [dout_WIDTH-1:0] w_a;
  logic signed [dout_WIDTH-1:0] w_b;
  logic        [dout_WIDTH-1:0] r_dout;

  // Low bits of a product only depend on the low bits of the sign-extended operands.
  assign w_a = dout_WIDTH'($signed(i_din0));
  assign w_b = dout_WIDTH'($signed(i_din1));

  always_ff @(posedge clk) begin
    if (i_ce) begin
      r_dout <= w_a * w_b;
    end
  end

  assign o_dout = r_dout;

endmodule
`default_nettype wire

// File: rtl/exo1_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : exo1_mul_arbiter
// Purpose  : Round-robin arbiter feeding a shared 2-cycle signed multiplier.
// Revision : 1.0 - initial release
// ============================================================================
module exo1_mul_arbiter
  import exo1_mul_pkg::*;
#(
  parameter int NREQ = C_NREQ_DEFAULT,
  parameter int W    = C_W_DEFAULT
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NREQ-1:0]             req_valid,
  output logic [NREQ-1:0]             req_ready,
  input  logic [NREQ*W-1:0]           req_a,
  input  logic [NREQ*W-1:0]           req_b,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [id_width(NREQ)-1:0]   rsp_id,
  output logic [W-1:0]                rsp_data,
  output logic                        busy
);

  localparam int ID_W = id_width(NREQ);

  logic            w_stall;
  logic            w_found;
  logic            w_accept;
  logic [ID_W-1:0] w_idx;
  logic [ID_W-1:0] w_scan;
  logic [NREQ-1:0] w_onehot;
  logic [W-1:0]    w_sel_a;
  logic [W-1:0]    w_sel_b;
  logic [W-1:0]    w_mul_dout;

  logic [ID_W-1:0] r_last;
  logic            r_iss_valid;
  logic [ID_W-1:0] r_iss_id;
  logic [W-1:0]    r_iss_a;
  logic [W-1:0]    r_iss_b;
  logic            r_mul_valid;
  logic [ID_W-1:0] r_mul_id;

  assign w_stall = r_mul_valid & ~rsp_ready;

  // Scan starts one past the last winner and wraps at NREQ-1.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    w_scan  = r_last;
    for (int k = 0; k < NREQ; k++) begin
      w_scan = (w_scan == ID_W'(NREQ - 1)) ? '0 : w_scan + ID_W'(1);
      if (!w_found && req_valid[w_scan]) begin
        w_found = 1'b1;
        w_idx   = w_scan;
      end
    end
  end

  always_comb begin
    w_onehot = '0;
    w_sel_a  = '0;
    w_sel_b  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_idx == ID_W'(i)) begin
        w_onehot[i] = 1'b1;
        w_sel_a     = req_a[i*W +: W];
        w_sel_b     = req_b[i*W +: W];
      end
    end
  end

  assign w_accept  = w_found & ~w_stall & ~reset;
  assign req_ready = w_accept ? w_onehot : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last      <= ID_W'(NREQ - 1);
      r_iss_valid <= 1'b0;
      r_mul_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_last <= w_idx;
      end
      if (!w_stall) begin
        r_iss_valid <= w_accept;
        r_iss_id    <= w_idx;
        r_iss_a     <= w_sel_a;
        r_iss_b     <= w_sel_b;
        r_mul_valid <= r_iss_valid;
        r_mul_id    <= r_iss_id;
      end
    end
  end

  exo1_mul_32s_32s_32_2_1 #(
    .din0_WIDTH (W),
    .din1_WIDTH (W),
    .dout_WIDTH (W)
  ) u_mul (
    .clk    (clk),
    .i_ce   (~w_stall),
    .i_din0 (r_iss_a),
    .i_din1 (r_iss_b),
    .o_dout (w_mul_dout)
  );

  assign rsp_valid = r_mul_valid;
  assign rsp_id    = r_mul_id;
  assign rsp_data  = w_mul_dout;
  assign busy      = ~reset & ((|req_valid) | r_iss_valid | r_mul_valid);

endmodule
`default_nettype wire

// File: tb/tb_exo1_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_exo1_mul_arbiter
// Purpose  : Directed self-checking bench for exo1_mul_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_exo1_mul_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_id;
  logic [W-1:0]      rsp_data;
  logic              busy;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  logic [31:0] exp_q[$];
  logic [31:0] rr_exp [4];
  logic [3:0]  exp_rdy;
  logic signed [31:0] ta;
  logic signed [31:0] tb;
  logic signed [63:0] tp;

  always #5 clk = ~clk;

  exo1_mul_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    step();
    step();
    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);

    // Single request, presented in the first cycle after reset
    step(); reset = 1'b0; set_op(0, 32'd7, 32'hFFFF_FFFD); req_valid = 4'b0001; #1;
    chk("single_grant", req_ready, 4'b0001);
    chk("single_busy", busy, 1);
    step(); req_valid = '0; #1;
    chk("single_lat1", rsp_valid, 0);
    chk("single_busy_inflight", busy, 1);
    step(); #1;
    chk("single_valid", rsp_valid, 1);
    chk("single_id", rsp_id, 0);
    chk("single_data", rsp_data, 32'hFFFF_FFEB);
    step(); #1;
    chk("single_done", rsp_valid, 0);
    chk("single_idle", busy, 0);

    // Overflow wrap
    step(); set_op(1, 32'h7FFF_FFFF, 32'd2); req_valid = 4'b0010; #1;
    chk("ovf_grant", req_ready, 4'b0010);
    step(); req_valid = '0; #1;
    step(); #1;
    chk("ovf_valid", rsp_valid, 1);
    chk("ovf_id", rsp_id, 1);
    chk("ovf_data", rsp_data, 32'hFFFF_FFFE);

    // Round robin from reset, all requesters active
    step(); reset = 1'b1; #1;
    rr_exp[0] = 32'h0000_001E;
    rr_exp[1] = 32'hFFFF_FFEE;
    rr_exp[2] = 32'hFFFF_FD44;
    rr_exp[3] = 32'h0000_0000;
    step(); reset = 1'b0;
    set_op(0, 32'd5, 32'd6);
    set_op(1, 32'hFFFF_FFFE, 32'd9);
    set_op(2, 32'd100, 32'hFFFF_FFF9);
    set_op(3, 32'h0001_0000, 32'h0001_0000);
    req_valid = 4'b1111; #1;
    for (int k = 0; k <= 10; k++) begin
      if (k > 0) begin
        step();
        if (k == 8) req_valid = '0;
        #1;
      end
      exp_rdy = (k < 8) ? (4'b0001 << (k % 4)) : 4'b0000;
      chk("rr_ready", req_ready, exp_rdy);
      if (k >= 2 && k < 10) begin
        chk("rr_valid", rsp_valid, 1);
        chk("rr_id", rsp_id, (k - 2) % 4);
        chk("rr_data", rsp_data, rr_exp[(k - 2) % 4]);
      end
      if (k == 10) chk("rr_drain", rsp_valid, 0);
    end

    // Backpressure with two operations in flight
    step();
    set_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    set_op(2, 32'h0001_2345, 32'h0000_0100);
    set_op(1, 32'hFFFF_FFF8, 32'd3);
    req_valid = 4'b0001; #1;
    chk("bp_grant0", req_ready, 4'b0001);
    step(); req_valid = 4'b0100; #1;
    chk("bp_grant2", req_ready, 4'b0100);
    for (int j = 0; j < 5; j++) begin
      step();
      if (j == 0) begin
        req_valid = 4'b0010;
        rsp_ready = 1'b0;
      end
      #1;
      chk("bp_hold_valid", rsp_valid, 1);
      chk("bp_hold_id", rsp_id, 0);
      chk("bp_hold_data", rsp_data, 32'h0000_0001);
      chk("bp_hold_ready", req_ready, 0);
    end
    step(); rsp_ready = 1'b1; #1;
    chk("bp_rel_valid", rsp_valid, 1);
    chk("bp_rel_id", rsp_id, 0);
    chk("bp_rel_grant", req_ready, 4'b0010);
    step(); req_valid = '0; #1;
    chk("bp_r2_valid", rsp_valid, 1);
    chk("bp_r2_id", rsp_id, 2);
    chk("bp_r2_data", rsp_data, 32'h0123_4500);
    step(); #1;
    chk("bp_r1_valid", rsp_valid, 1);
    chk("bp_r1_id", rsp_id, 1);
    chk("bp_r1_data", rsp_data, 32'hFFFF_FFE8);
    step(); #1;
    chk("bp_empty", rsp_valid, 0);

    // Reset while two operations are in flight
    step(); set_op(1, 32'd5, 32'd5); set_op(3, 32'd6, 32'd6); req_valid = 4'b0010; #1;
    chk("mf_grant1", req_ready, 4'b0010);
    step(); req_valid = 4'b1000; #1;
    chk("mf_grant3", req_ready, 4'b1000);
    step(); req_valid = '0; reset = 1'b1; #1;
    step(); reset = 1'b0; set_op(0, 32'd9, 32'd9); req_valid = 4'b1011; #1;
    chk("mf_no_valid", rsp_valid, 0);
    chk("mf_grant0", req_ready, 4'b0001);
    step(); req_valid = '0; #1;
    chk("mf_no_valid2", rsp_valid, 0);
    step(); #1;
    chk("mf_valid", rsp_valid, 1);
    chk("mf_id", rsp_id, 0);
    chk("mf_data", rsp_data, 32'h0000_0051);
    step(); #1;
    chk("mf_empty", rsp_valid, 0);

    // Back-to-back throughput from a single requester
    for (int k = 0; k <= 18; k++) begin
      step();
      if (k < 16) begin
        if (k == 0) begin
          ta = 32'sh8000_0000;
          tb = 32'shFFFF_FFFF;
        end else begin
          ta = $signed($urandom);
          tb = $signed($urandom);
        end
        set_op(3, ta, tb);
        req_valid = 4'b1000;
        tp = ta * tb;
        exp_q.push_back(tp[31:0]);
      end else begin
        req_valid = '0;
      end
      #1;
      if (k < 16) chk("tp_ready", req_ready, 4'b1000);
      if (k >= 2 && k < 18) begin
        chk("tp_valid", rsp_valid, 1);
        chk("tp_id", rsp_id, 3);
        if (exp_q.size() > 0) chk("tp_data", rsp_data, exp_q.pop_front());
      end
      if (k == 18) chk("tp_end", rsp_valid, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
